// File: rtl/axis_pkg.sv
// Shared types and the round-robin search helper for the AXI-Stream arbiter.
package axis_pkg;

  localparam int MAX_PORTS     = 16;
  localparam int MAX_IDX_WIDTH = 4;

  typedef logic [MAX_IDX_WIDTH-1:0] idx_t;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_e;

  // Index of the first set request at or after ptr, wrapping modulo num_ports.
  // Only meaningful when at least one request bit is set.
  function automatic idx_t rr_pick(input logic [MAX_PORTS-1:0] req,
                                   input idx_t                 ptr,
                                   input int                   num_ports);
    idx_t pick;
    logic found;
    int   idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (i < num_ports) begin
        idx = int'(ptr) + i;
        if (idx >= num_ports) idx = idx - num_ports;
        if (!found && req[idx[3:0]]) begin
          pick  = idx_t'(idx);
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Two-entry AXI-Stream register slice; in_ready is a flop so there is no
// combinational path from out_ready back to in_ready.
module axis_skid_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;

  assign in_ready = ~skid_valid;

  // The main register refills from the skid entry first so beat order is kept;
  // a new beat only lands in the skid entry while the main one is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (out_ready || !out_valid) begin
      if (skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end
    end else if (in_valid && !skid_valid) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI-Stream sink among
// NUM_PORTS sources; the grant is held from first beat to tlast.
module axis_rr_arbiter
  import axis_pkg::*;
#(
  parameter  int NUM_PORTS   = 4,
  parameter  int DATA_WIDTH  = 128,
  parameter  int LAST_ENABLE = 1,
  localparam int IDX_WIDTH   = $clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_PORTS-1:0]            s_tvalid,
  input  logic [NUM_PORTS-1:0]            s_tlast,
  output logic [NUM_PORTS-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]           m_tdata,
  output logic                            m_tvalid,
  output logic                            m_tlast,
  output logic [IDX_WIDTH-1:0]            m_tid,
  input  logic                            m_tready,
  output logic                            busy
);

  localparam int PAYLOAD_WIDTH = DATA_WIDTH + 1 + IDX_WIDTH;

  arb_state_e                state;
  logic [IDX_WIDTH-1:0]      rr_ptr;
  logic [IDX_WIDTH-1:0]      grant;
  logic [MAX_PORTS-1:0]      req_ext;
  idx_t                      ptr_ext;
  idx_t                      pick;

  logic                      beat_valid;
  logic                      beat_last;
  logic                      beat_fire;
  logic [DATA_WIDTH-1:0]     beat_data;
  logic                      skid_in_ready;
  logic [PAYLOAD_WIDTH-1:0]  skid_in;
  logic [PAYLOAD_WIDTH-1:0]  skid_out;

  always_comb begin
    req_ext                  = '0;
    req_ext[NUM_PORTS-1:0]   = s_tvalid;
    ptr_ext                  = '0;
    ptr_ext[IDX_WIDTH-1:0]   = rr_ptr;
    pick                     = rr_pick(req_ext, ptr_ext, NUM_PORTS);
  end

  assign beat_valid = (state == GRANT) && s_tvalid[grant];
  assign beat_data  = s_tdata[grant*DATA_WIDTH +: DATA_WIDTH];
  assign beat_last  = (LAST_ENABLE == 0) ? 1'b1 : s_tlast[grant];
  assign beat_fire  = beat_valid && skid_in_ready;

  always_comb begin
    s_tready = '0;
    if (state == GRANT) s_tready[grant] = skid_in_ready;
  end

  // The winner is registered, costing one IDLE cycle between packets but
  // keeping the search off the ready path. rr_ptr wraps by explicit compare
  // because NUM_PORTS need not be a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      grant  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|s_tvalid) begin
            grant <= pick[IDX_WIDTH-1:0];
            state <= GRANT;
          end
        end
        GRANT: begin
          if (beat_fire && beat_last) begin
            rr_ptr <= (grant == IDX_WIDTH'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign skid_in = {beat_last, grant, beat_data};

  axis_skid_reg #(
    .WIDTH (PAYLOAD_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   (skid_in),
    .in_valid  (beat_valid),
    .in_ready  (skid_in_ready),
    .out_data  (skid_out),
    .out_valid (m_tvalid),
    .out_ready (m_tready)
  );

  assign m_tdata = skid_out[DATA_WIDTH-1:0];
  assign m_tid   = skid_out[DATA_WIDTH +: IDX_WIDTH];
  assign m_tlast = skid_out[PAYLOAD_WIDTH-1];
  assign busy    = (state == GRANT);

endmodule
